stopwatch_bcd4: RTL and testbench

- Four-digit BCD stopwatch, format SS.hh: seconds 00-59, hundredths 00-99.
- Sits directly upstream of the 4x7 segment display controller. It drives that controller's four 4-bit digit inputs and four decimal-point inputs.
- Internal prescaler turns SysClk into a 100 Hz count tick.
- Run/pause/clear are controlled by already-debounced button levels.

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/bcd_digit.sv | 33 +++
 rtl/stopwatch_bcd4.sv | 127 ++++++++++++
 tb/tb_stopwatch_bcd4.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and per-digit limits for the SS.hh stopwatch
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    localparam logic [3:0] HUND_MAX  = 4'd9;
    localparam logic [3:0] TENTH_MAX = 4'd9;
    localparam logic [3:0] SEC_U_MAX = 4'd9;
    localparam logic [3:0] SEC_T_MAX = 4'd5;

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit: one BCD digit counter with synchronous clear and carry-out
// Ports:
//   SysClk, Reset : clock and synchronous active-high reset
//   clr           : force the digit to 0 on the next edge
//   inc           : advance the digit by one on the next edge
//   max           : last value before the digit rolls over to 0
//   q             : current digit value (registered)
//   carry         : inc & (q == max), feeds the next digit's inc
module bcd_digit (
    input  logic       SysClk,
    input  logic       Reset,
    input  logic       clr,
    input  logic       inc,
    input  logic [3:0] max,
    output logic [3:0] q,
    output logic       carry
);

    logic [3:0] q_q, q_d;

    always_comb begin
        carry = inc & (q_q == max);
        q_d   = (clr || carry) ? 4'd0 : inc ? q_q + 4'd1 : q_q;
    end

    always_ff @(posedge SysClk) begin
        if (Reset) q_q <= 4'd0;
        else       q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/stopwatch_bcd4.sv
// stopwatch_bcd4: four-digit BCD stopwatch (SS.hh) driving a 4x7 segment display controller
// Ports:
//   SysClk, Reset            : clock and synchronous active-high reset
//   StartStop, Clear, Lap    : debounced button levels (rising edges act)
//   Digit1..Digit4           : tens of seconds, seconds, tenths, hundredths
//   Dp0..Dp3                 : decimal points; Dp1 lit, Dp3 blinks while running
//   Running                  : high in RUN
//   Wrap                     : one-cycle pulse on 59.99 -> 00.00
// Build option: define STOPWATCH_LAP_HOLD_EN to add the lap-freeze display register.
module stopwatch_bcd4
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV = 500000,
    parameter int PRESC_W  = 24
) (
    input  logic       SysClk,
    input  logic       Reset,
    input  logic       StartStop,
    input  logic       Clear,
    input  logic       Lap,
    output logic [3:0] Digit1,
    output logic [3:0] Digit2,
    output logic [3:0] Digit3,
    output logic [3:0] Digit4,
    output logic       Dp0,
    output logic       Dp1,
    output logic       Dp2,
    output logic       Dp3,
    output logic       Running,
    output logic       Wrap
);

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               ss_prev_q, clr_prev_q, wrap_q;
    logic               ss_rise, clr_rise, count_en, tick, clear_go;
    logic [3:0]         d1, d2, d3, d4;
    logic               c1, c2, c3, c4;
    logic               run;

    // A StartStop rise in RUN pauses on that edge, so the prescaler holds
    // its value and a resumed partial period continues where it stopped.
    always_comb begin
        ss_rise  = StartStop & ~ss_prev_q;
        clr_rise = Clear & ~clr_prev_q;
        run      = state_q == ST_RUN;
        count_en = run && !ss_rise;
        tick     = count_en && presc_q == PRESC_W'(TICK_DIV - 1);
        clear_go = state_q == ST_PAUSE && clr_rise;
        presc_d  = (state_q == ST_IDLE || clear_go || tick) ? '0 :
                   count_en ? presc_q + PRESC_W'(1) : presc_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = ss_rise ? ST_RUN : ST_IDLE;
            ST_RUN:   state_d = ss_rise ? ST_PAUSE : ST_RUN;
            ST_PAUSE: state_d = clr_rise ? ST_IDLE : ss_rise ? ST_RUN : ST_PAUSE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            presc_q    <= '0;
            ss_prev_q  <= 1'b0;
            clr_prev_q <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            ss_prev_q  <= StartStop;
            clr_prev_q <= Clear;
            wrap_q     <= c1;
        end
    end

    bcd_digit u_hund  (.SysClk(SysClk), .Reset(Reset), .clr(clear_go), .inc(tick), .max(HUND_MAX),  .q(d4), .carry(c4));
    bcd_digit u_tenth (.SysClk(SysClk), .Reset(Reset), .clr(clear_go), .inc(c4),   .max(TENTH_MAX), .q(d3), .carry(c3));
    bcd_digit u_sec_u (.SysClk(SysClk), .Reset(Reset), .clr(clear_go), .inc(c3),   .max(SEC_U_MAX), .q(d2), .carry(c2));
    bcd_digit u_sec_t (.SysClk(SysClk), .Reset(Reset), .clr(clear_go), .inc(c2),   .max(SEC_T_MAX), .q(d1), .carry(c1));

    assign Dp0     = 1'b0;
    assign Dp1     = 1'b1;
    assign Dp2     = 1'b0;
    assign Running = run;
    assign Wrap    = wrap_q;

`ifdef STOPWATCH_LAP_HOLD_EN
    logic        lap_prev_q, frozen_q, frozen_d;
    logic [15:0] disp_q, disp_d;
    logic        lap_rise, freeze, release_hold;

    // Freeze captures the live count; any second Lap rise, a pause or a
    // Clear rise lets the display track the live count again.
    always_comb begin
        lap_rise     = Lap & ~lap_prev_q;
        freeze       = !frozen_q && run && lap_rise;
        release_hold = frozen_q && (lap_rise || (run && ss_rise) || clr_rise);
        frozen_d     = release_hold ? 1'b0 : freeze ? 1'b1 : frozen_q;
        disp_d       = freeze ? {d1, d2, d3, d4} : disp_q;
    end

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            lap_prev_q <= 1'b0;
            frozen_q   <= 1'b0;
            disp_q     <= 16'h0000;
        end else begin
            lap_prev_q <= Lap;
            frozen_q   <= frozen_d;
            disp_q     <= disp_d;
        end
    end

    assign {Digit1, Digit2, Digit3, Digit4} = frozen_q ? disp_q : {d1, d2, d3, d4};
    assign Dp3 = frozen_q | (run & d3[0]);
`else
    logic lap_unused;
    assign lap_unused = Lap;
    assign {Digit1, Digit2, Digit3, Digit4} = {d1, d2, d3, d4};
    assign Dp3 = run & d3[0];
`endif

endmodule

// File: tb/tb_stopwatch_bcd4.sv
// tb_stopwatch_bcd4: self-checking bench for stopwatch_bcd4 with TICK_DIV=4
module tb_stopwatch_bcd4;

    localparam int TD = 4;

    logic       SysClk = 1'b0;
    logic       Reset = 1'b1, StartStop = 1'b0, Clear = 1'b0, Lap = 1'b0;
    logic [3:0] Digit1, Digit2, Digit3, Digit4;
    logic       Dp0, Dp1, Dp2, Dp3, Running, Wrap;

    stopwatch_bcd4 #(.TICK_DIV(TD), .PRESC_W(8)) dut (
        .SysClk(SysClk), .Reset(Reset), .StartStop(StartStop), .Clear(Clear), .Lap(Lap),
        .Digit1(Digit1), .Digit2(Digit2), .Digit3(Digit3), .Digit4(Digit4),
        .Dp0(Dp0), .Dp1(Dp1), .Dp2(Dp2), .Dp3(Dp3), .Running(Running), .Wrap(Wrap)
    );

    always #5 SysClk = ~SysClk;

    int          vecs = 0, errs = 0;
    logic [21:0] exp_q[$];
    logic [21:0] e;

    // Reference model: count kept as an integer number of hundredths.
    int m_st = 0, m_presc = 0, m_cnt = 0, m_disp = 0;
    bit m_pss = 0, m_pclr = 0, m_plap = 0, m_wrap = 0, m_frz = 0;

    function automatic logic [21:0] m_out();
        int  s;
        bit  dp3;
        s   = m_frz ? m_disp : m_cnt;
        dp3 = m_frz || (m_st == 1 && ((m_cnt / 10) % 10) % 2 == 1);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10),
                1'b0, 1'b1, 1'b0, dp3, m_st == 1, m_wrap};
    endfunction

    function automatic logic [21:0] obs();
        return {Digit1, Digit2, Digit3, Digit4, Dp0, Dp1, Dp2, Dp3, Running, Wrap};
    endfunction

    task automatic model_step();
        bit ssr, cr, lr, en, tk, cg;
        int st_n;
        if (Reset) begin
            m_st = 0; m_presc = 0; m_cnt = 0; m_disp = 0;
            m_pss = 0; m_pclr = 0; m_plap = 0; m_wrap = 0; m_frz = 0;
        end else begin
            ssr  = StartStop && !m_pss;
            cr   = Clear && !m_pclr;
            lr   = Lap && !m_plap;
            en   = m_st == 1 && !ssr;
            tk   = en && m_presc == TD - 1;
            cg   = m_st == 2 && cr;
            st_n = m_st == 0 ? (ssr ? 1 : 0) : m_st == 1 ? (ssr ? 2 : 1) : (cr ? 0 : ssr ? 1 : 2);
`ifdef STOPWATCH_LAP_HOLD_EN
            if (m_frz && (lr || (m_st == 1 && ssr) || cr)) m_frz = 0;
            else if (!m_frz && m_st == 1 && lr) begin
                m_frz  = 1;
                m_disp = m_cnt;
            end
`endif
            m_wrap  = tk && m_cnt == 5999;
            m_presc = (m_st == 0 || cg || tk) ? 0 : en ? m_presc + 1 : m_presc;
            m_cnt   = cg ? 0 : tk ? (m_cnt + 1) % 6000 : m_cnt;
            m_st    = st_n;
            m_pss   = StartStop;
            m_pclr  = Clear;
            m_plap  = Lap;
        end
    endtask

    task automatic step();
        model_step();
        exp_q.push_back(m_out());
        @(posedge SysClk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 5; i++) begin
            Reset = i < 3;
            step();
            e = exp_q.pop_front();
            vecs++;
            if (obs() !== e) begin errs++; $display("FAIL reset cyc %0d: got %h want %h", i, obs(), e); end
            if (i == 3) begin
                vecs++;
                if ({Digit1, Digit2, Digit3, Digit4, Dp0, Dp1, Dp2, Dp3, Running, Wrap} !== 22'b0100_00) begin
                    errs++;
                    $display("FAIL reset_state: got %h want %h", obs(), 22'h000010);
                end
            end
        end
    endtask

    // Held StartStop gives one toggle; Clear while running is ignored.
    task automatic test_start();
        for (int i = 0; i < 46; i++) begin
            Reset     = i < 2;
            StartStop = i >= 2 && i < 6;
            Clear     = i >= 20 && i < 25;
            step();
            e = exp_q.pop_front();
            vecs++;
            if (obs() !== e) begin errs++; $display("FAIL start cyc %0d: got %h want %h", i, obs(), e); end
            if (i == 2 || i == 5 || i == 6 || i == 42) begin
                vecs++;
                if (i == 2 && Running !== 1'b1) begin errs++; $display("FAIL start_running: got %b want 1", Running); end
                if (i == 5 && Digit4 !== 4'd0) begin errs++; $display("FAIL first_tick_early: got %0d want 0", Digit4); end
                if (i == 6 && Digit4 !== 4'd1) begin errs++; $display("FAIL first_tick: got %0d want 1", Digit4); end
                if (i == 42 && {Digit1, Digit2, Digit3, Digit4} !== 16'h0010) begin
                    errs++; $display("FAIL count_40: got %h want 0010", {Digit1, Digit2, Digit3, Digit4});
                end
            end
        end
    endtask

    task automatic test_wrap();
        int wraps = 0;
        Clear = 1'b0;
        for (int i = 0; i < 24010; i++) begin
            Reset     = i < 2;
            StartStop = i == 2;
            step();
            e = exp_q.pop_front();
            vecs++;
            if (obs() !== e) begin errs++; $display("FAIL wrap cyc %0d: got %h want %h", i, obs(), e); end
            if (Wrap === 1'b1) wraps++;
            if (i == 24001) begin
                vecs++;
                if ({Digit1, Digit2, Digit3, Digit4, Wrap} !== {16'h5999, 1'b0}) begin
                    errs++; $display("FAIL at_5999: got %h w%b want 5999 w0", {Digit1, Digit2, Digit3, Digit4}, Wrap);
                end
            end
            if (i == 24002) begin
                vecs++;
                if ({Digit1, Digit2, Digit3, Digit4, Wrap} !== {16'h0000, 1'b1}) begin
                    errs++; $display("FAIL rollover: got %h w%b want 0000 w1", {Digit1, Digit2, Digit3, Digit4}, Wrap);
                end
            end
        end
        vecs++;
        if (wraps != 1) begin errs++; $display("FAIL wrap_pulses: got %0d want 1", wraps); end
    endtask

    // Pause at 00.07 with prescaler 2, resume, next tick two edges later.
    task automatic test_pause();
        for (int i = 0; i < 62; i++) begin
            Reset     = i < 2;
            StartStop = i == 2 || (i >= 33 && i < 36) || i == 55;
            step();
            e = exp_q.pop_front();
            vecs++;
            if (obs() !== e) begin errs++; $display("FAIL pause cyc %0d: got %h want %h", i, obs(), e); end
            if (i == 33 || i == 54) begin
                vecs++;
                if ({Digit1, Digit2, Digit3, Digit4, Running} !== {16'h0007, 1'b0}) begin
                    errs++; $display("FAIL paused: got %h r%b want 0007 r0", {Digit1, Digit2, Digit3, Digit4}, Running);
                end
            end
            if (i == 56 || i == 57) begin
                vecs++;
                if (Digit4 !== (i == 56 ? 4'd7 : 4'd8)) begin
                    errs++; $display("FAIL resume_tick cyc %0d: got %0d want %0d", i, Digit4, i == 56 ? 7 : 8);
                end
            end
        end
    endtask

    // Simultaneous StartStop and Clear rises in PAUSE: Clear wins.
    task automatic test_clear();
        for (int i = 0; i < 52; i++) begin
            Reset     = i < 2;
            StartStop = i == 2 || i == 33 || (i >= 40 && i < 43) || i == 45;
            Clear     = (i >= 40 && i < 43) || i == 47;
            step();
            e = exp_q.pop_front();
            vecs++;
            if (obs() !== e) begin errs++; $display("FAIL clear cyc %0d: got %h want %h", i, obs(), e); end
            if (i == 40) begin
                vecs++;
                if ({Digit1, Digit2, Digit3, Digit4, Running} !== {16'h0000, 1'b0}) begin
                    errs++; $display("FAIL clear_wins: got %h r%b want 0000 r0", {Digit1, Digit2, Digit3, Digit4}, Running);
                end
            end
            if (i == 49) begin
                vecs++;
                if ({Digit1, Digit2, Digit3, Digit4} !== 16'h0001) begin
                    errs++; $display("FAIL restart: got %h want 0001", {Digit1, Digit2, Digit3, Digit4});
                end
            end
        end
    endtask

    // Reset mid-RUN wins over a coincident StartStop rise.
    task automatic test_reset_mid();
        for (int i = 0; i < 26; i++) begin
            Reset     = i < 2 || i == 20;
            StartStop = i == 2 || i == 20;
            step();
            e = exp_q.pop_front();
            vecs++;
            if (obs() !== e) begin errs++; $display("FAIL rstmid cyc %0d: got %h want %h", i, obs(), e); end
            if (i == 20) begin
                vecs++;
                if ({Digit1, Digit2, Digit3, Digit4, Running, Wrap} !== 18'h0) begin
                    errs++; $display("FAIL reset_mid: got %h r%b want 0000 r0", {Digit1, Digit2, Digit3, Digit4}, Running);
                end
            end
        end
    endtask

    task automatic test_lap();
        for (int i = 0; i < 52; i++) begin
            Reset     = i < 2;
            StartStop = i == 2;
            Lap       = (i >= 23 && i <= 43) || (i >= 45 && i <= 47);
            step();
            e = exp_q.pop_front();
            vecs++;
            if (obs() !== e) begin errs++; $display("FAIL lap cyc %0d: got %h want %h", i, obs(), e); end
`ifdef STOPWATCH_LAP_HOLD_EN
            if (i == 43) begin
                vecs++;
                if ({Digit1, Digit2, Digit3, Digit4, Dp3} !== {16'h0005, 1'b1}) begin
                    errs++; $display("FAIL lap_hold: got %h dp%b want 0005 dp1", {Digit1, Digit2, Digit3, Digit4}, Dp3);
                end
            end
`else
            if (i == 43) begin
                vecs++;
                if ({Digit1, Digit2, Digit3, Digit4} !== 16'h0010) begin
                    errs++; $display("FAIL lap_ignored: got %h want 0010", {Digit1, Digit2, Digit3, Digit4});
                end
            end
`endif
            if (i == 45) begin
                vecs++;
                if ({Digit1, Digit2, Digit3, Digit4} !== 16'h0010) begin
                    errs++; $display("FAIL lap_release: got %h want 0010", {Digit1, Digit2, Digit3, Digit4});
                end
            end
        end
        Lap = 1'b0;
    endtask

    initial begin
        test_reset();
        test_start();
        test_wrap();
        test_pause();
        test_clear();
        test_reset_mid();
        test_lap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
